// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the two-producer FIFO write arbiter.
// Holds the default FIFO data width and burst length. It also holds the arbiter
// state encoding, both as plain 2-bit constants used by the RTL and as an enum
// that gives readable names in waveforms and benches.
package fifo_arb_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_BURST_LEN  = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StGnt0 = GNT0,
        StGnt1 = GNT1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshakes and FIFO write-port signals around the arbiter.
//   req0/req1, data0/data1          : producer write requests and data
//   gnt0/gnt1, ack0/ack1            : registered grant, write-accepted strobe
//   fifo_wr_en, fifo_data_in        : FIFO write port
//   fifo_wr_ack/overflow/full       : FIFO status (ack/overflow lag the write by one cycle)
//   ovf_err                         : sticky overflow error
// master = the arbiter side, slave = the producers plus the FIFO.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH
);

    logic                  req0;
    logic                  req1;
    logic [FIFO_WIDTH-1:0] data0;
    logic [FIFO_WIDTH-1:0] data1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  ack0;
    logic                  ack1;
    logic                  fifo_wr_en;
    logic [FIFO_WIDTH-1:0] fifo_data_in;
    logic                  fifo_wr_ack;
    logic                  fifo_overflow;
    logic                  fifo_full;
    logic                  ovf_err;

    modport master (
        input  req0, req1, data0, data1,
        input  fifo_wr_ack, fifo_overflow, fifo_full,
        output gnt0, gnt1, ack0, ack1,
        output fifo_wr_en, fifo_data_in, ovf_err
    );

    modport slave (
        output req0, req1, data0, data1,
        output fifo_wr_ack, fifo_overflow, fifo_full,
        input  gnt0, gnt1, ack0, ack1,
        input  fifo_wr_en, fifo_data_in, ovf_err
    );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges two producers onto one FIFO write port.
// A grant lasts until its requester drops or BURST_LEN writes have been issued.
// Each issued write is tagged with its owner, so the FIFO's delayed wr_ack goes
// back to the producer that issued the write, and a delayed overflow sets a
// sticky error flag.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if master modport (producers + FIFO write port)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus
);

    localparam int unsigned        BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              tag_valid_q;
    logic              tag_id_q;
    logic              ovf_q;

    logic gnt0, gnt1, granted;
    logic cur_idx;
    logic req_own, req_other;
    logic wr_en;
    logic burst_done;
    logic release_k;

    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign granted = gnt0 | gnt1;
    assign cur_idx = gnt1;

    assign req_own   = gnt1 ? bus.req1 : bus.req0;
    assign req_other = gnt1 ? bus.req0 : bus.req1;

    // A full FIFO stalls the owner without costing it a beat or the grant.
    assign wr_en      = granted & req_own & ~bus.fifo_full;
    assign burst_done = wr_en & (beat_q == BEAT_LAST);
    assign release_k  = granted & (~req_own | burst_done);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (bus.req0 && bus.req1) begin
                    // Tie goes to whoever was not served last.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (bus.req0) begin
                    state_d = GNT0;
                end else if (bus.req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (release_k) begin
                    last_d = cur_idx;
                    beat_d = '0;
                    if (req_other) begin
                        // Hand over directly, no idle bubble.
                        state_d = gnt1 ? GNT0 : GNT1;
                    end else if (req_own) begin
                        // Burst limit hit with nobody waiting: re-grant.
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(wr_en);
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // The write tag lines up the FIFO's one-cycle-late status with the write
    // that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= 1'b0;
            tag_id_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            tag_valid_q <= wr_en;
            tag_id_q    <= cur_idx;
            if (bus.fifo_overflow && tag_valid_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = gnt0 ? bus.data0 : (gnt1 ? bus.data1 : '0);
    assign bus.ack0         = bus.fifo_wr_ack & tag_valid_q & ~tag_id_q;
    assign bus.ack1         = bus.fifo_wr_ack & tag_valid_q & tag_id_q;
    assign bus.ovf_err      = ovf_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.gnt0 && bus.gnt1));
    a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.fifo_wr_en && bus.fifo_full));

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16: data width of both producers and of the FIFO write port.
REQ-002 Parameter BURST_LEN, default 4: maximum writes per grant before re-arbitration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  producer write requests; each held high while data is pending.
REQ-006 data0, data1  input  FIFO_WIDTH each  producer write data, valid with the request.
REQ-007 gnt0, gnt1  output  1 each  registered grant; at most one high.
REQ-008 ack0, ack1  output  1 each  write-accepted strobe routed back to the owning producer.
REQ-009 fifo_wr_en  output  1  FIFO write enable.
REQ-010 fifo_data_in  output  FIFO_WIDTH  FIFO write data.
REQ-011 fifo_wr_ack, fifo_overflow, fifo_full  input  1 each  FIFO status; wr_ack/overflow refer to the previous cycle's write.
REQ-012 ovf_err  output  1  sticky error: FIFO reported overflow on a write issued by this block.

Function
REQ-013 FSM states IDLE, GNT0, GNT1; gnt0 = (state==GNT0), gnt1 = (state==GNT1).
REQ-014 Round-robin pointer last_served (1 bit): IDLE with both requests grants the requester != last_served; a single request is granted directly.
REQ-015 Grant latency: request sampled high in IDLE at edge N -> gnt high after edge N.
REQ-016 fifo_wr_en = gnt_k & req_k & !fifo_full (combinational); fifo_data_in = data_k of the granted requester, else 0.
REQ-017 Never issue fifo_wr_en while fifo_full is high; grant is retained through full, no beat counted.
REQ-018 beat_cnt (width clog2(BURST_LEN)+1) increments on every edge where fifo_wr_en is high; cleared on every grant change or re-grant.
REQ-019 Release at an edge when req_k is low, or when a write is issued with beat_cnt == BURST_LEN-1.
REQ-020 On release: other requester high -> go directly to its GNT state (no idle bubble); else if burst limit and req_k still high -> stay in GNT_k with beat_cnt cleared; else -> IDLE.
REQ-021 last_served updates to k on every release from GNT_k.
REQ-022 Write tag: registered tag_valid <= fifo_wr_en, tag_id <= granted index; ack_k = fifo_wr_ack & tag_valid & (tag_id==k), one cycle after the write.
REQ-023 ovf_err set when fifo_overflow & tag_valid; cleared only by reset.
REQ-024 fifo_wr_ack high with tag_valid low is ignored (no ack pulse).

Reset
REQ-025 rst_n low asynchronously forces state IDLE, last_served=1 (req0 wins first tie), beat_cnt=0, tag_valid=0, tag_id=0, ovf_err=0.
REQ-026 During reset all outputs are 0: gnt0/1, ack0/1, fifo_wr_en, fifo_data_in, ovf_err.
REQ-027 Reset mid-burst drops fifo_wr_en in the same cycle; no ack is produced for the write pending at reset.

Structure
REQ-028 Shared package fifo_arb_pkg holds the state enum typedef and FIFO_WIDTH/BURST_LEN defaults.
REQ-029 Single module; no sub-module; FSM, pointer, beat counter and tag pipeline are inline.

Verification
REQ-030 Reset; req0=1 only, FIFO empty -> gnt0 after 1 edge, 4 writes of data0, ack0 each cycle after, re-grant GNT0 with beat_cnt 0.
REQ-031 req0=req1=1 from reset -> GNT0 for 4 writes, then GNT1 directly with no IDLE cycle, alternating thereafter.
REQ-032 GNT1, fifo_full forced high for 3 cycles -> fifo_wr_en low, beat_cnt frozen, gnt1 held; resumes when full drops.
REQ-033 req0 drops after 2 writes while req1=1 -> GNT1 next cycle; ack0 still pulses for the second write, not ack1.
REQ-034 Assert rst_n low mid-burst in GNT0 -> gnt0, fifo_wr_en, ack0 all 0 immediately; after release req1-only -> gnt1.
REQ-035 Inject fifo_overflow one cycle after a write -> ovf_err=1 and stays 1 until reset; spurious fifo_wr_ack with no write -> no ack pulse.
